clip_controller: RTL and testbench

Parametrised record/playback sequencer for the audio recorder. It sits between the deserializer (record path), the serializer (playback path) and one shared single-port BRAM partitioned into `NUM_CLIPS` equal clip regions. It generates memory addresses and enables, and tracks the recorded length of every clip. Playback therefore stops at the recorded end rather than at the region end. Button inputs arrive already synchronised and reduced to single-cycle pulses.

---
 rtl/clip_pkg.sv | 18 +
 rtl/clip_controller_if.sv | 27 ++
 rtl/clip_length_table.sv | 48 ++++
 rtl/clip_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_clip_controller.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clip_pkg.sv
// Shared types for the clip record/playback sequencer: FSM state encoding
// and the clip-region base address helper.
package clip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REC,
    PLAY_RD,
    PLAY_WAIT,
    PLAY_OUT
  } clip_state_t;

  // First BRAM address of a clip region; callers truncate to their address width.
  function automatic int unsigned clip_base(input int unsigned clip, input int unsigned depth);
    return clip * depth;
  endfunction

endpackage

// File: rtl/clip_controller_if.sv
// Sample streams and BRAM port A of the clip sequencer.
// master: the sequencer side; slave: deserializer/serializer/BRAM side.
interface clip_controller_if #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 18
);
  logic                sample_in_valid;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_out_valid;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_out_ready;
  logic                mem_en;
  logic                mem_wen;
  logic [ADDR_W-1:0]   mem_addr;
  logic [SAMPLE_W-1:0] mem_wdata;
  logic [SAMPLE_W-1:0] mem_rdata;

  modport master (
    input  sample_in_valid, sample_in, sample_out_ready, mem_rdata,
    output sample_out_valid, sample_out, mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output sample_in_valid, sample_in, sample_out_ready, mem_rdata,
    input  sample_out_valid, sample_out, mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/clip_length_table.sv
// Recorded length of every clip: one write port, one combinational read
// port, and a per-clip non-empty flag. All lengths clear on reset.
module clip_length_table #(
  parameter int NUM_CLIPS = 2,
  parameter int LEN_W     = 18,
  parameter int CLIP_W    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [CLIP_W-1:0]    waddr,
  input  logic [LEN_W-1:0]     wdata,
  input  logic [CLIP_W-1:0]    raddr,
  output logic [LEN_W-1:0]     rdata,
  output logic [NUM_CLIPS-1:0] has_data
);

  logic [LEN_W-1:0] len_q [NUM_CLIPS];
  logic [LEN_W-1:0] len_d [NUM_CLIPS];

  // Next-state: only the addressed entry takes the write data.
  always_comb begin
    for (int i = 0; i < NUM_CLIPS; i++) begin
      len_d[i] = len_q[i];
      if (we && (waddr == CLIP_W'(i))) len_d[i] = wdata;
    end
  end

  // Length registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= len_d[i];
    end
  end

  // Read mux and non-empty flags; an out-of-range read returns 0.
  always_comb begin
    rdata    = '0;
    has_data = '0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (raddr == CLIP_W'(i)) rdata = len_q[i];
      has_data[i] = (len_q[i] != '0);
    end
  end

endmodule

// File: rtl/clip_controller.sv
// Record/playback sequencer over a shared single-port BRAM split into
// NUM_CLIPS regions of CLIP_DEPTH samples. Playback stops at the recorded
// length of the clip. Define CLIP_LOOP_EN to add the loop_mode input, which
// makes playback wrap to the clip start until stopped.
//
// state     | meaning
// IDLE      | waiting for a record/play request
// REC       | writing incoming samples to the active clip
// PLAY_RD   | read issued to BRAM for the current offset
// PLAY_WAIT | BRAM data returning, captured into sample_out
// PLAY_OUT  | sample_out_valid held until the serializer accepts it
module clip_controller
  import clip_pkg::*;
#(
  parameter int NUM_CLIPS  = 2,
  parameter int CLIP_DEPTH = 131072,
  parameter int SAMPLE_W   = 16,
  localparam int CLIP_W    = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1,
  localparam int LEN_W     = $clog2(CLIP_DEPTH + 1),
  localparam int ADDR_W    = $clog2(NUM_CLIPS * CLIP_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CLIP_W-1:0]    clip_sel,
  input  logic                 record_req,
  input  logic                 play_req,
  input  logic                 stop_req,
`ifdef CLIP_LOOP_EN
  input  logic                 loop_mode,
`endif
  clip_controller_if.master    bus,
  output logic [CLIP_W-1:0]    active_clip,
  output logic                 recording,
  output logic                 playing,
  output logic                 done,
  output logic [NUM_CLIPS-1:0] clip_has_data
);

  clip_state_t         state_q, state_d;
  logic [LEN_W-1:0]    ofs_q, ofs_d, ofs_inc;
  logic [CLIP_W-1:0]   active_q, active_d;
  logic                done_q, done_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [SAMPLE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;

  logic                clip_ok;
  logic [CLIP_W-1:0]   rd_clip;
  logic [LEN_W-1:0]    rd_len;
  logic                len_we;
  logic [LEN_W-1:0]    len_wdata;
  logic                loop_active;

`ifdef CLIP_LOOP_EN
  logic loop_q, loop_d;
  assign loop_active = loop_q;
`else
  assign loop_active = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] addr_of(input logic [CLIP_W-1:0] clip,
                                                input logic [LEN_W-1:0]  ofs);
    return ADDR_W'(clip_base(32'(clip), 32'(CLIP_DEPTH)) + 32'(ofs));
  endfunction

  // In IDLE the table is read for the requested clip (zero-length check),
  // otherwise for the clip being played.
  assign rd_clip = (state_q == IDLE) ? clip_sel : active_q;
  assign ofs_inc = ofs_q + LEN_W'(1);

  clip_length_table #(
    .NUM_CLIPS (NUM_CLIPS),
    .LEN_W     (LEN_W),
    .CLIP_W    (CLIP_W)
  ) u_len (
    .clock    (clock),
    .reset    (reset),
    .we       (len_we),
    .waddr    (active_q),
    .wdata    (len_wdata),
    .raddr    (rd_clip),
    .rdata    (rd_len),
    .has_data (clip_has_data)
  );

  // Range check without a constant-folding compare when NUM_CLIPS is a power of two.
  always_comb begin
    clip_ok = 1'b0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (clip_sel == CLIP_W'(i)) clip_ok = 1'b1;
    end
  end

  // Next-state, memory port and length-table write decisions.
  always_comb begin
    state_d      = state_q;
    ofs_d        = ofs_q;
    active_d     = active_q;
    done_d       = 1'b0;
    mem_en_d     = 1'b0;
    mem_wen_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sample_out_d = sample_out_q;
    len_we       = 1'b0;
    len_wdata    = ofs_q;
`ifdef CLIP_LOOP_EN
    loop_d       = loop_q;
`endif

    case (state_q)
      IDLE: begin
        if (clip_ok && record_req) begin
          state_d  = REC;
          active_d = clip_sel;
          ofs_d    = '0;
        end else if (clip_ok && play_req) begin
          active_d = clip_sel;
          ofs_d    = '0;
          if (rd_len == '0) begin
            done_d = 1'b1;
          end else begin
            // Read is issued on entry so mem_en appears the cycle after the request.
            state_d    = PLAY_RD;
            mem_en_d   = 1'b1;
            mem_addr_d = addr_of(clip_sel, '0);
`ifdef CLIP_LOOP_EN
            loop_d     = loop_mode;
`endif
          end
        end
      end

      REC: begin
        if (bus.sample_in_valid) begin
          mem_en_d    = 1'b1;
          mem_wen_d   = 1'b1;
          mem_addr_d  = addr_of(active_q, ofs_q);
          mem_wdata_d = bus.sample_in;
          ofs_d       = ofs_inc;
        end
        // A sample arriving with stop is kept; the region-full end coincides with the last write.
        if (stop_req || (bus.sample_in_valid && (ofs_inc == LEN_W'(CLIP_DEPTH)))) begin
          len_we    = 1'b1;
          len_wdata = ofs_d;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      PLAY_RD: begin
        if (stop_req) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = PLAY_WAIT;
        end
      end

      PLAY_WAIT: begin
        if (stop_req) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sample_out_d = bus.mem_rdata;
          state_d      = PLAY_OUT;
        end
      end

      PLAY_OUT: begin
        if (stop_req) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (bus.sample_out_ready) begin
          if ((ofs_inc == rd_len) && !loop_active) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ofs_d      = (ofs_inc == rd_len) ? '0 : ofs_inc;
            mem_en_d   = 1'b1;
            mem_addr_d = addr_of(active_q, ofs_d);
            state_d    = PLAY_RD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      ofs_q        <= '0;
      active_q     <= '0;
      done_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      sample_out_q <= '0;
    end else begin
      state_q      <= state_d;
      ofs_q        <= ofs_d;
      active_q     <= active_d;
      done_q       <= done_d;
      mem_en_q     <= mem_en_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      sample_out_q <= sample_out_d;
    end
  end

`ifdef CLIP_LOOP_EN
  // Loop mode is latched at play start so mid-play toggles have no effect.
  always_ff @(posedge clock) begin
    if (!reset) loop_q <= 1'b0;
    else        loop_q <= loop_d;
  end
`endif

  assign bus.mem_en           = mem_en_q;
  assign bus.mem_wen          = mem_wen_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.sample_out       = sample_out_q;
  assign bus.sample_out_valid = (state_q == PLAY_OUT);

  assign active_clip = active_q;
  assign recording   = (state_q == REC);
  assign playing     = (state_q == PLAY_RD) || (state_q == PLAY_WAIT) || (state_q == PLAY_OUT);
  assign done        = done_q;

endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller with NUM_CLIPS=2, CLIP_DEPTH=8, and a
// one-cycle-latency BRAM model.
module tb_clip_controller;

  localparam int NUM_CLIPS  = 2;
  localparam int CLIP_DEPTH = 8;
  localparam int SAMPLE_W   = 16;
  localparam int ADDR_W     = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clip_sel = 1'b0;
  logic       record_req = 1'b0;
  logic       play_req = 1'b0;
  logic       stop_req = 1'b0;
`ifdef CLIP_LOOP_EN
  logic       loop_mode = 1'b0;
`endif
  logic       active_clip;
  logic       recording;
  logic       playing;
  logic       done;
  logic [1:0] clip_has_data;

  int checks = 0;
  int errors = 0;
  int mem_en_cnt = 0;
  int wr8_cnt = 0;
  int done_cnt = 0;

  logic [SAMPLE_W-1:0] mem [16];

  clip_controller_if #(.SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)) bus ();

  clip_controller #(
    .NUM_CLIPS  (NUM_CLIPS),
    .CLIP_DEPTH (CLIP_DEPTH),
    .SAMPLE_W   (SAMPLE_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clip_sel      (clip_sel),
    .record_req    (record_req),
    .play_req      (play_req),
    .stop_req      (stop_req),
`ifdef CLIP_LOOP_EN
    .loop_mode     (loop_mode),
`endif
    .bus           (bus),
    .active_clip   (active_clip),
    .recording     (recording),
    .playing       (playing),
    .done          (done),
    .clip_has_data (clip_has_data)
  );

  always #5 clock = ~clock;

  // BRAM model plus event counters.
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
      else             bus.mem_rdata <= mem[bus.mem_addr];
      mem_en_cnt <= mem_en_cnt + 1;
    end
    if (bus.mem_en && bus.mem_wen && (bus.mem_addr == 4'd8)) wr8_cnt <= wr8_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick;
    checks++; if (bus.mem_en !== 1'b0 || bus.mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b%b want 00", bus.mem_en, bus.mem_wen); end
    checks++; if (bus.mem_addr !== 4'd0 || bus.mem_wdata !== 16'd0) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.sample_out_valid !== 1'b0 || bus.sample_out !== 16'd0) begin errors++; $display("FAIL reset_sample_out got %b/%h want 0/0", bus.sample_out_valid, bus.sample_out); end
    checks++; if ({recording, playing, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {recording, playing, done}); end
    checks++; if (active_clip !== 1'b0 || clip_has_data !== 2'b00) begin errors++; $display("FAIL reset_clip got %b/%b want 0/00", active_clip, clip_has_data); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_play_empty;
    int en0;
    en0 = mem_en_cnt;
    clip_sel = 1'b0; play_req = 1'b1;
    tick;
    play_req = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_play_done got %b want 1", done); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL empty_play_playing got %b want 0", playing); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_play_done_pulse got %b want 0", done); end
    repeat (3) tick;
    checks++; if (mem_en_cnt !== en0) begin errors++; $display("FAIL empty_play_mem_en got %0d want %0d", mem_en_cnt, en0); end
  endtask

  task automatic test_record_stop;
    clip_sel = 1'b1; record_req = 1'b1;
    tick;
    record_req = 1'b0;
    checks++; if (recording !== 1'b1 || active_clip !== 1'b1) begin errors++; $display("FAIL rec_start got %b/%b want 1/1", recording, active_clip); end
    for (int i = 0; i < 5; i++) begin
      bus.sample_in_valid = 1'b1;
      bus.sample_in = 16'(32'hA0 + i);
      if (i == 0) begin play_req = 1'b1; clip_sel = 1'b0; end
      tick;
      play_req = 1'b0;
      if (i == 0) begin
        checks++; if (recording !== 1'b1 || playing !== 1'b0 || active_clip !== 1'b1) begin errors++; $display("FAIL rec_busy_ignore got %b%b/%b want 10/1", recording, playing, active_clip); end
      end
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_wen !== 1'b1 || bus.mem_addr !== 4'(8 + i) || bus.mem_wdata !== 16'(32'hA0 + i)) begin
        errors++; $display("FAIL rec_write%0d got en%b wen%b %h:%h want en1 wen1 %h:%h", i, bus.mem_en, bus.mem_wen, bus.mem_addr, bus.mem_wdata, 4'(8 + i), 16'(32'hA0 + i));
      end
    end
    bus.sample_in_valid = 1'b0;
    stop_req = 1'b1;
    tick;
    stop_req = 1'b0;
    checks++; if (done !== 1'b1 || recording !== 1'b0) begin errors++; $display("FAIL rec_stop_done got %b/%b want 1/0", done, recording); end
    checks++; if (clip_has_data !== 2'b10) begin errors++; $display("FAIL rec_has_data got %b want 10", clip_has_data); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rec_done_pulse got %b want 0", done); end
  endtask

  task automatic test_play_clip1;
    int wait_cyc;
    bus.sample_out_ready = 1'b1;
    clip_sel = 1'b1; play_req = 1'b1;
    tick;
    play_req = 1'b0;
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_addr !== 4'd8) begin errors++; $display("FAIL play_first_read got en%b wen%b %h want en1 wen0 8", bus.mem_en, bus.mem_wen, bus.mem_addr); end
    wait_cyc = 1;
    for (int k = 0; k < 5; k++) begin
      while (!bus.sample_out_valid && wait_cyc < 10) begin tick; wait_cyc++; end
      checks++; if (wait_cyc !== 3) begin errors++; $display("FAIL play_latency%0d got %0d want 3", k, wait_cyc); end
      checks++; if (bus.sample_out !== 16'(32'hA0 + k)) begin errors++; $display("FAIL play_data%0d got %h want %h", k, bus.sample_out, 16'(32'hA0 + k)); end
      tick;
      wait_cyc = 1;
      if (k < 4) begin
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 4'(9 + k)) begin errors++; $display("FAIL play_read%0d got en%b %h want en1 %h", k + 1, bus.mem_en, bus.mem_addr, 4'(9 + k)); end
      end
    end
    checks++; if (done !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL play_end got %b/%b want 1/0", done, playing); end
    tick;
  endtask

  task automatic test_record_full;
    int w0, n, bad, cyc;
    w0 = wr8_cnt;
    clip_sel = 1'b0; record_req = 1'b1;
    tick;
    record_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sample_in_valid = 1'b1;
      bus.sample_in = 16'(32'hB0 + i);
      tick;
    end
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 4'd7 || bus.mem_wdata !== 16'hB7) begin errors++; $display("FAIL full_last_write got en%b %h:%h want en1 7:00b7", bus.mem_en, bus.mem_addr, bus.mem_wdata); end
    checks++; if (done !== 1'b1 || recording !== 1'b0) begin errors++; $display("FAIL full_auto_end got %b/%b want 1/0", done, recording); end
    bus.sample_in = 16'hBEEF;
    tick;
    bus.sample_in_valid = 1'b0;
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL full_extra_write got en%b want 0", bus.mem_en); end
    tick;
    checks++; if (wr8_cnt !== w0) begin errors++; $display("FAIL full_addr8_write got %0d want %0d", wr8_cnt, w0); end
    checks++; if (clip_has_data !== 2'b11) begin errors++; $display("FAIL full_has_data got %b want 11", clip_has_data); end
    bus.sample_out_ready = 1'b1;
    clip_sel = 1'b0; play_req = 1'b1;
    tick;
    play_req = 1'b0;
    n = 0; bad = 0; cyc = 0;
    while (!done && cyc < 60) begin
      if (bus.sample_out_valid) begin
        if (bus.sample_out !== 16'(32'hB0 + n)) bad++;
        n++;
      end
      tick;
      cyc++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL full_play_count got %0d want 8", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_play_data got %0d wrong want 0", bad); end
    tick;
  endtask

  task automatic test_same_cycle;
    clip_sel = 1'b0; record_req = 1'b1; play_req = 1'b1;
    tick;
    record_req = 1'b0; play_req = 1'b0;
    checks++; if (recording !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL same_cycle got rec%b play%b want rec1 play0", recording, playing); end
    stop_req = 1'b1;
    tick;
    stop_req = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_rec_done got %b want 1", done); end
    checks++; if (clip_has_data !== 2'b10) begin errors++; $display("FAIL zero_rec_has_data got %b want 10", clip_has_data); end
    tick;
  endtask

  task automatic test_stall_stop;
    bus.sample_out_ready = 1'b1;
    clip_sel = 1'b1; play_req = 1'b1;
    tick;
    play_req = 1'b0;
    tick;
    tick;
    checks++; if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== 16'hA0) begin errors++; $display("FAIL stall_first got %b/%h want 1/00a0", bus.sample_out_valid, bus.sample_out); end
    tick;
    bus.sample_out_ready = 1'b0;
    tick;
    tick;
    checks++; if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== 16'hA1) begin errors++; $display("FAIL stall_second got %b/%h want 1/00a1", bus.sample_out_valid, bus.sample_out); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== 16'hA1) begin errors++; $display("FAIL stall_hold%0d got %b/%h want 1/00a1", i, bus.sample_out_valid, bus.sample_out); end
    end
    stop_req = 1'b1;
    tick;
    stop_req = 1'b0;
    checks++; if (bus.sample_out_valid !== 1'b0) begin errors++; $display("FAIL stall_stop_valid got %b want 0", bus.sample_out_valid); end
    checks++; if (done !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL stall_stop_done got %b/%b want 1/0", done, playing); end
    bus.sample_out_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid_record;
    int d0;
    d0 = done_cnt;
    clip_sel = 1'b0; record_req = 1'b1;
    tick;
    record_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.sample_in_valid = 1'b1;
      bus.sample_in = 16'(32'hD0 + i);
      tick;
    end
    bus.sample_in_valid = 1'b0;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL reset_mid_done got %0d want %0d", done_cnt, d0); end
    checks++; if (clip_has_data !== 2'b00 || recording !== 1'b0) begin errors++; $display("FAIL reset_mid_state got %b/%b want 00/0", clip_has_data, recording); end
  endtask

`ifdef CLIP_LOOP_EN
  task automatic test_loop;
    int d0, n, bad, cyc;
    clip_sel = 1'b0; record_req = 1'b1;
    tick;
    record_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sample_in_valid = 1'b1;
      bus.sample_in = 16'(32'hC0 + i);
      tick;
    end
    bus.sample_in_valid = 1'b0;
    stop_req = 1'b1;
    tick;
    stop_req = 1'b0;
    tick;
    d0 = done_cnt;
    loop_mode = 1'b1;
    bus.sample_out_ready = 1'b1;
    play_req = 1'b1;
    tick;
    play_req = 1'b0;
    loop_mode = 1'b0;
    n = 0; bad = 0; cyc = 0;
    while (n < 7 && cyc < 60) begin
      if (bus.sample_out_valid) begin
        if (bus.sample_out !== 16'(32'hC0 + (n % 3))) bad++;
        n++;
      end
      tick;
      cyc++;
    end
    checks++; if (n !== 7 || bad !== 0) begin errors++; $display("FAIL loop_seq got %0d samples %0d wrong want 7/0", n, bad); end
    checks++; if (done_cnt !== d0 || playing !== 1'b1) begin errors++; $display("FAIL loop_no_done got %0d/%b want %0d/1", done_cnt, playing, d0); end
    stop_req = 1'b1;
    tick;
    stop_req = 1'b0;
    checks++; if (done !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL loop_stop got %b/%b want 1/0", done, playing); end
    tick;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.mem_rdata        = '0;
    bus.sample_in_valid  = 1'b0;
    bus.sample_in        = '0;
    bus.sample_out_ready = 1'b0;
    test_reset;
    test_play_empty;
    test_record_stop;
    test_play_clip1;
    test_record_full;
    test_same_cycle;
    test_stall_stop;
    test_reset_mid_record;
`ifdef CLIP_LOOP_EN
    test_loop;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
